// File: rtl/upd7800_bus_sched_pkg.sv
// Shared types for the uPD7800 bus scheduler: FSM state encoding and
// the phase index that selects which CPU clock strobe a step produces.
package upd7800_bus_sched_pkg;

  typedef enum logic [1:0] {
    SCH_CPU  = 2'd0,
    SCH_DMA  = 2'd1,
    SCH_TURN = 2'd2
  } e_sched_st;

  localparam logic [1:0] PH_CP1P = 2'd0;
  localparam logic [1:0] PH_CP1N = 2'd1;
  localparam logic [1:0] PH_CP2P = 2'd2;
  localparam logic [1:0] PH_CP2N = 2'd3;

endpackage

// File: rtl/upd7800_phase_gen.sv
// CPU clock phase generator. A divider counts CLK; when it reaches DIV-1 a
// step is flagged, and the following CLK emits the one-cycle strobe for the
// current phase and advances the phase. Dropping run parks everything at
// phase 0 with no pending step, so the CPU clock restarts cleanly.
module upd7800_phase_gen
  import upd7800_bus_sched_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       run,
  output logic       CP1_POSEDGE,
  output logic       CP1_NEGEDGE,
  output logic       CP2_POSEDGE,
  output logic       CP2_NEGEDGE,
  output logic [1:0] ph
);

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

  logic [3:0] div_q, div_d;
  logic [1:0] ph_q, ph_d;
  logic       step_q, step_d;
  logic [3:0] stb_q, stb_d;

  // Divider / pending-step / strobe next state; a stopped generator is parked
  always_comb begin
    div_d  = div_q;
    ph_d   = ph_q;
    step_d = 1'b0;
    stb_d  = '0;
    if (run) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        step_d = 1'b1;
      end else begin
        div_d = div_q + 4'd1;
      end
      if (step_q) begin
        stb_d[ph_q] = 1'b1;
        ph_d        = ph_q + 2'd1;
      end
    end else begin
      div_d = '0;
      ph_d  = PH_CP1P;
    end
  end

  // Counter and strobe registers
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      div_q  <= '0;
      ph_q   <= PH_CP1P;
      step_q <= 1'b0;
      stb_q  <= '0;
    end else begin
      div_q  <= div_d;
      ph_q   <= ph_d;
      step_q <= step_d;
      stb_q  <= stb_d;
    end
  end

  assign CP1_POSEDGE = stb_q[PH_CP1P];
  assign CP1_NEGEDGE = stb_q[PH_CP1N];
  assign CP2_POSEDGE = stb_q[PH_CP2P];
  assign CP2_NEGEDGE = stb_q[PH_CP2N];
  assign ph          = ph_q;

endmodule

// File: rtl/upd7800_bus_sched.sv
// uPD7800 shared-bus scheduler. The CPU owns the bus and is clocked by the
// phase generator; a video DMA master may take the bus only at a machine-cycle
// boundary (the CP2_NEGEDGE strobe) while the CPU is idle and its post-release
// credit has run out. After DMA releases, a TURN gap of DIV CLKs keeps both
// strobes high before the CPU clock restarts at phase 0.
module upd7800_bus_sched
  import upd7800_bus_sched_pkg::*;
#(
  parameter int DIV     = 2,
  parameter int CPU_MIN = 2
) (
  input  logic        CLK,
  input  logic        RESETB,
  output logic        CP1_POSEDGE,
  output logic        CP1_NEGEDGE,
  output logic        CP2_POSEDGE,
  output logic        CP2_NEGEDGE,
  input  logic [15:0] CPU_A,
  input  logic [7:0]  CPU_DO,
  input  logic        CPU_RDB,
  input  logic        CPU_WRB,
  input  logic        DMA_REQ,
  output logic        DMA_GNT,
  input  logic [15:0] DMA_A,
  input  logic [7:0]  DMA_DO,
  input  logic        DMA_RDB,
  input  logic        DMA_WRB,
  output logic [15:0] MEM_A,
  output logic [7:0]  MEM_DO,
  output logic        MEM_RDB,
  output logic        MEM_WRB
);

  localparam logic [3:0] DIV_LAST  = 4'(DIV - 1);
  localparam logic [3:0] CREDIT_LD = 4'(CPU_MIN);

  e_sched_st  st_q, st_d;
  logic [3:0] credit_q, credit_d;
  logic [3:0] turn_q, turn_d;
  logic       gnt_q;
  logic       run;
  logic       boundary;
  logic [1:0] ph;

  upd7800_phase_gen #(
    .DIV (DIV)
  ) u_phase (
    .CLK         (CLK),
    .RESETB      (RESETB),
    .run         (run),
    .CP1_POSEDGE (CP1_POSEDGE),
    .CP1_NEGEDGE (CP1_NEGEDGE),
    .CP2_POSEDGE (CP2_POSEDGE),
    .CP2_NEGEDGE (CP2_NEGEDGE),
    .ph          (ph)
  );

  // The CP2_NEGEDGE strobe marks the end of a machine cycle; the phase has
  // already wrapped to 0 by then.
  assign boundary = (st_q == SCH_CPU) && CP2_NEGEDGE && (ph == PH_CP1P);

  // The CPU clock only runs while the CPU keeps the bus this cycle and next,
  // so no strobe can leak into the first DMA cycle even when DIV=1.
  assign run = (st_q == SCH_CPU) && (st_d == SCH_CPU);

  // Scheduler next state: grant at a boundary, release on request drop, TURN gap
  always_comb begin
    st_d     = st_q;
    credit_d = credit_q;
    turn_d   = turn_q;
    case (st_q)
      SCH_CPU: begin
        if (boundary) begin
          // The credit spent by the machine cycle just finished counts
          // toward this grant decision.
          credit_d = (credit_q != 4'd0) ? credit_q - 4'd1 : 4'd0;
          if (DMA_REQ && CPU_RDB && CPU_WRB && (credit_d == 4'd0)) begin
            st_d = SCH_DMA;
          end
        end
      end
      SCH_DMA: begin
        if (!DMA_REQ) begin
          st_d   = SCH_TURN;
          turn_d = '0;
        end
      end
      SCH_TURN: begin
        if (turn_q == DIV_LAST) begin
          st_d     = SCH_CPU;
          credit_d = CREDIT_LD;
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: begin
        st_d = SCH_CPU;
      end
    endcase
  end

  // Scheduler state, credit, TURN counter and registered grant
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      st_q     <= SCH_CPU;
      credit_q <= '0;
      turn_q   <= '0;
      gnt_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      credit_q <= credit_d;
      turn_q   <= turn_d;
      gnt_q    <= (st_d == SCH_DMA);
    end
  end

  assign DMA_GNT = gnt_q;

  // Shared memory bus mux; strobes are held inactive in TURN and in reset
  always_comb begin
    MEM_A   = CPU_A;
    MEM_DO  = CPU_DO;
    MEM_RDB = CPU_RDB;
    MEM_WRB = CPU_WRB;
    case (st_q)
      SCH_DMA: begin
        MEM_A   = DMA_A;
        MEM_DO  = DMA_DO;
        MEM_RDB = DMA_RDB;
        MEM_WRB = DMA_WRB;
      end
      SCH_TURN: begin
        MEM_RDB = 1'b1;
        MEM_WRB = 1'b1;
      end
      default: ;
    endcase
    if (!RESETB) begin
      MEM_RDB = 1'b1;
      MEM_WRB = 1'b1;
    end
  end

endmodule

// File: tb/tb_upd7800_bus_sched.sv
// Bench for upd7800_bus_sched: two instances (DIV=2 and DIV=1, CPU_MIN=2)
// share all inputs. A timing model derived from the strobe/grant rules
// (elapsed CLKs since the CPU clock started, CP2_NEGEDGE count since release)
// predicts every output; scenario tasks compare against it and against
// hand-derived constants.
module tb_upd7800_bus_sched;

  localparam int DIV0    = 2;
  localparam int DIV1    = 1;
  localparam int CPU_MIN = 2;

  logic        CLK = 1'b0;
  logic        RESETB = 1'b1;
  logic [15:0] CPU_A = '0, DMA_A = '0;
  logic [7:0]  CPU_DO = '0, DMA_DO = '0;
  logic        CPU_RDB = 1'b1, CPU_WRB = 1'b1;
  logic        DMA_REQ = 1'b0, DMA_RDB = 1'b1, DMA_WRB = 1'b1;

  logic [3:0]  stb0, stb1;
  logic        gnt0, gnt1, rd0, wr0, rd1, wr1;
  logic [15:0] ma0, ma1;
  logic [7:0]  mdo0, mdo1;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  upd7800_bus_sched #(.DIV(DIV0), .CPU_MIN(CPU_MIN)) u_dut (
    .CLK(CLK), .RESETB(RESETB),
    .CP1_POSEDGE(stb0[0]), .CP1_NEGEDGE(stb0[1]), .CP2_POSEDGE(stb0[2]), .CP2_NEGEDGE(stb0[3]),
    .CPU_A(CPU_A), .CPU_DO(CPU_DO), .CPU_RDB(CPU_RDB), .CPU_WRB(CPU_WRB),
    .DMA_REQ(DMA_REQ), .DMA_GNT(gnt0),
    .DMA_A(DMA_A), .DMA_DO(DMA_DO), .DMA_RDB(DMA_RDB), .DMA_WRB(DMA_WRB),
    .MEM_A(ma0), .MEM_DO(mdo0), .MEM_RDB(rd0), .MEM_WRB(wr0)
  );

  upd7800_bus_sched #(.DIV(DIV1), .CPU_MIN(CPU_MIN)) u_dut1 (
    .CLK(CLK), .RESETB(RESETB),
    .CP1_POSEDGE(stb1[0]), .CP1_NEGEDGE(stb1[1]), .CP2_POSEDGE(stb1[2]), .CP2_NEGEDGE(stb1[3]),
    .CPU_A(CPU_A), .CPU_DO(CPU_DO), .CPU_RDB(CPU_RDB), .CPU_WRB(CPU_WRB),
    .DMA_REQ(DMA_REQ), .DMA_GNT(gnt1),
    .DMA_A(DMA_A), .DMA_DO(DMA_DO), .DMA_RDB(DMA_RDB), .DMA_WRB(DMA_WRB),
    .MEM_A(ma1), .MEM_DO(mdo1), .MEM_RDB(rd1), .MEM_WRB(wr1)
  );

  // ---------------- reference model ----------------
  // md: 0 = CPU owns bus, 1 = DMA, 2 = turnaround
  // tt: CLK edges since the CPU clock (re)started
  // nc: CP2_NEGEDGE strobes seen since the last DMA release
  int md[2], tt[2], tl[2], nc[2];
  logic [3:0] ms;

  function automatic int dvf(int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  // Strobe k (k=0,1,2..) appears DIV*(k+1)+1 edges after the clock restarts
  function automatic logic [3:0] m_stb(int i);
    int d;
    int idx;
    d = dvf(i);
    m_stb = '0;
    if (md[i] == 0 && tt[i] >= d + 1 && ((tt[i] - 1) % d) == 0) begin
      idx = ((tt[i] - 1) / d - 1) % 4;
      m_stb = 4'b0001 << idx;
    end
  endfunction

  function automatic logic [30:0] exp_vec(int i);
    logic [3:0] s;
    logic g, r, w;
    logic [15:0] a;
    logic [7:0] d;
    s = m_stb(i);
    g = (md[i] == 1);
    a = (md[i] == 1) ? DMA_A : CPU_A;
    d = (md[i] == 1) ? DMA_DO : CPU_DO;
    r = (md[i] == 0) ? CPU_RDB : (md[i] == 1) ? DMA_RDB : 1'b1;
    w = (md[i] == 0) ? CPU_WRB : (md[i] == 1) ? DMA_WRB : 1'b1;
    if (!RESETB) begin
      r = 1'b1;
      w = 1'b1;
    end
    return {s, g, r, w, a, d};
  endfunction

  function automatic logic [30:0] dut_vec(int i);
    if (i == 0) return {stb0, gnt0, rd0, wr0, ma0, mdo0};
    return {stb1, gnt1, rd1, wr1, ma1, mdo1};
  endfunction

  always @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      for (int i = 0; i < 2; i++) begin
        md[i] = 0; tt[i] = 0; tl[i] = 0; nc[i] = CPU_MIN;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (md[i])
          0: begin
            ms = m_stb(i);
            if (ms[3]) begin
              if (nc[i] < 100) nc[i]++;
              if (DMA_REQ && CPU_RDB && CPU_WRB && nc[i] >= CPU_MIN) md[i] = 1;
              else tt[i]++;
            end else begin
              tt[i]++;
            end
          end
          1: if (!DMA_REQ) begin md[i] = 2; tl[i] = dvf(i); end
          default: begin
            tl[i]--;
            if (tl[i] == 0) begin md[i] = 0; tt[i] = 0; nc[i] = 0; end
          end
        endcase
      end
    end
  end

  // Structural properties on every cycle out of reset
  always @(negedge CLK) begin
    if (RESETB) begin
      tests++;
      if ($countones(stb0) > 1 || $countones(stb1) > 1) begin
        fails++;
        $display("FAIL strobe_onehot t=%0t stb0=%b stb1=%b required at most one", $time, stb0, stb1);
      end
      tests++;
      if ((gnt0 && |stb0) || (gnt1 && |stb1)) begin
        fails++;
        $display("FAIL gnt_vs_strobe t=%0t gnt0=%b stb0=%b gnt1=%b stb1=%b required no overlap",
                 $time, gnt0, stb0, gnt1, stb1);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int first0, first1;
    RESETB = 1'b1;
    #1 RESETB = 1'b0;
    CPU_RDB = 1'b0; CPU_WRB = 1'b0;
    repeat (3) @(negedge CLK);
    tests++;
    if ({stb0, gnt0, rd0, wr0} !== 7'b0000011) begin
      fails++; $display("FAIL reset_outputs0 got %b want 0000011", {stb0, gnt0, rd0, wr0});
    end
    tests++;
    if ({stb1, gnt1, rd1, wr1} !== 7'b0000011) begin
      fails++; $display("FAIL reset_outputs1 got %b want 0000011", {stb1, gnt1, rd1, wr1});
    end
    CPU_RDB = 1'b1; CPU_WRB = 1'b1;
    RESETB = 1'b1;
    first0 = -1; first1 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (first0 < 0 && stb0[0]) first0 = k;
      if (first1 < 0 && stb1[0]) first1 = k;
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec(i) !== exp_vec(i)) begin
          fails++; $display("FAIL reset_release%0d t=%0t got %h want %h", i, $time, dut_vec(i), exp_vec(i));
        end
      end
    end
    tests++;
    if (first0 != DIV0 + 1) begin
      fails++; $display("FAIL first_cp1p_div2 got %0d edges want %0d", first0, DIV0 + 1);
    end
    tests++;
    if (first1 != DIV1 + 1) begin
      fails++; $display("FAIL first_cp1p_div1 got %0d edges want %0d", first1, DIV1 + 1);
    end
  endtask

  task automatic test_free_run();
    int last, nexp;
    last = -1; nexp = 0;
    DMA_REQ = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec(i) !== exp_vec(i)) begin
          fails++; $display("FAIL free_run%0d t=%0t got %h want %h", i, $time, dut_vec(i), exp_vec(i));
        end
      end
      if (|stb0) begin
        if (last >= 0) begin
          tests++;
          if (stb0 !== (4'b0001 << nexp) || (k - last) != DIV0) begin
            fails++; $display("FAIL strobe_seq got %b after %0d clk want %b after %0d", stb0, k - last, 4'b0001 << nexp, DIV0);
          end
        end
        nexp = 0;
        for (int b = 0; b < 4; b++) if (stb0[b]) nexp = (b + 1) % 4;
        last = k;
      end
      CPU_A = 16'($urandom); CPU_DO = 8'($urandom);
      CPU_RDB = 1'($urandom); CPU_WRB = 1'($urandom);
    end
    tests++;
    if (gnt0 !== 1'b0) begin
      fails++; $display("FAIL free_run_gnt got %b want 0", gnt0);
    end
    CPU_RDB = 1'b1; CPU_WRB = 1'b1;
  endtask

  task automatic test_dma_grant();
    logic prev_cp2n;
    logic got;
    got = 1'b0;
    DMA_A = 16'h3F00; DMA_DO = 8'h5A;
    repeat ($urandom_range(0, 7)) @(negedge CLK);
    DMA_REQ = 1'b1;
    prev_cp2n = stb0[3];
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec(i) !== exp_vec(i)) begin
          fails++; $display("FAIL dma_grant%0d t=%0t got %h want %h", i, $time, dut_vec(i), exp_vec(i));
        end
      end
      if (gnt0) begin
        got = 1'b1;
        tests++;
        if (!prev_cp2n) begin
          fails++; $display("FAIL grant_after_cp2n prev_cp2n=%b want 1", prev_cp2n);
        end
      end
      prev_cp2n = stb0[3];
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL grant_timeout gnt0=%b want 1 within 20 clk", gnt0);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      tests++;
      if ({gnt0, stb0, ma0} !== {1'b1, 4'b0000, 16'h3F00}) begin
        fails++; $display("FAIL dma_hold got gnt=%b stb=%b a=%h want 1 0000 3f00", gnt0, stb0, ma0);
      end
    end
  endtask

  task automatic test_turn();
    int n_turn, n_cp2n;
    logic got;
    repeat (5) @(negedge CLK);
    DMA_RDB = 1'b0; DMA_WRB = 1'b0; CPU_RDB = 1'b0; CPU_WRB = 1'b0;
    DMA_REQ = 1'b0;
    n_turn = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec(i) !== exp_vec(i)) begin
          fails++; $display("FAIL turn%0d t=%0t got %h want %h", i, $time, dut_vec(i), exp_vec(i));
        end
      end
      if (!gnt0 && rd0 && wr0) n_turn++;
      if (k == 0) DMA_REQ = 1'b1;
    end
    tests++;
    if (n_turn != DIV0) begin
      fails++; $display("FAIL turn_length got %0d clk want %0d", n_turn, DIV0);
    end
    CPU_RDB = 1'b1; CPU_WRB = 1'b1; DMA_RDB = 1'b1; DMA_WRB = 1'b1;
    n_cp2n = 0; got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec(i) !== exp_vec(i)) begin
          fails++; $display("FAIL regrant%0d t=%0t got %h want %h", i, $time, dut_vec(i), exp_vec(i));
        end
      end
      if (gnt0) got = 1'b1;
      else if (stb0[3]) n_cp2n++;
    end
    tests++;
    if (!got || n_cp2n != CPU_MIN) begin
      fails++; $display("FAIL regrant_credit got gnt=%b after %0d cp2n want 1 after %0d", got, n_cp2n, CPU_MIN);
    end
  endtask

  task automatic test_defer();
    int n;
    logic prev_cp2n, got;
    DMA_REQ = 1'b0;
    n = 0;
    for (int k = 0; k < 80 && n < 3; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec(i) !== exp_vec(i)) begin
          fails++; $display("FAIL defer_drain%0d t=%0t got %h want %h", i, $time, dut_vec(i), exp_vec(i));
        end
      end
      if (stb0[3]) n++;
    end
    tests++;
    if (n != 3) begin
      fails++; $display("FAIL defer_drain_timeout got %0d cp2n want 3", n);
    end
    CPU_RDB = 1'b0; DMA_REQ = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      tests++;
      if (gnt0 !== 1'b0 || dut_vec(1) !== exp_vec(1)) begin
        fails++; $display("FAIL defer_busy t=%0t gnt0=%b want 0, dut1 %h want %h", $time, gnt0, dut_vec(1), exp_vec(1));
      end
    end
    CPU_RDB = 1'b1;
    prev_cp2n = stb0[3]; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      tests++;
      if (dut_vec(0) !== exp_vec(0)) begin
        fails++; $display("FAIL defer_release t=%0t got %h want %h", $time, dut_vec(0), exp_vec(0));
      end
      if (gnt0) begin
        got = 1'b1;
        tests++;
        if (!prev_cp2n) begin
          fails++; $display("FAIL defer_boundary prev_cp2n=%b want 1", prev_cp2n);
        end
      end
      prev_cp2n = stb0[3];
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL defer_grant_timeout gnt0=%b want 1", gnt0);
    end
  endtask

  task automatic test_reset_mid_dma();
    int first0;
    DMA_RDB = 1'b0; DMA_WRB = 1'b0;
    @(negedge CLK);
    tests++;
    if ({gnt0, rd0, wr0} !== 3'b100) begin
      fails++; $display("FAIL pre_reset_dma got %b want 100", {gnt0, rd0, wr0});
    end
    #2 RESETB = 1'b0;
    #1;
    tests++;
    if ({gnt0, rd0, wr0, gnt1, rd1, wr1} !== 6'b011011) begin
      fails++; $display("FAIL async_reset got %b want 011011", {gnt0, rd0, wr0, gnt1, rd1, wr1});
    end
    DMA_REQ = 1'b0; DMA_RDB = 1'b1; DMA_WRB = 1'b1;
    @(negedge CLK);
    RESETB = 1'b1;
    first0 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (first0 < 0 && stb0[0]) first0 = k;
      tests++;
      if (dut_vec(0) !== exp_vec(0)) begin
        fails++; $display("FAIL rerun t=%0t got %h want %h", $time, dut_vec(0), exp_vec(0));
      end
    end
    tests++;
    if (first0 != DIV0 + 1) begin
      fails++; $display("FAIL rerun_first_cp1p got %0d want %0d", first0, DIV0 + 1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec(i) !== exp_vec(i)) begin
          fails++; $display("FAIL random%0d t=%0t got %h want %h", i, $time, dut_vec(i), exp_vec(i));
        end
      end
      if ($urandom_range(0, 7) == 0) DMA_REQ = ~DMA_REQ;
      CPU_RDB = ($urandom_range(0, 3) != 0);
      CPU_WRB = ($urandom_range(0, 3) != 0);
      DMA_RDB = 1'($urandom); DMA_WRB = 1'($urandom);
      CPU_A = 16'($urandom); CPU_DO = 8'($urandom);
      DMA_A = 16'($urandom); DMA_DO = 8'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_dma_grant();
    test_turn();
    test_defer();
    test_reset_mid_dma();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
